// File: rtl/ctrl_types_pkg.sv
// ============================================================================
// Module : ctrl_types_pkg
// Brief  : Cache controller operation encoding shared by the controller and
//          every front-end that issues operations to it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_types_pkg;

  typedef enum logic [1:0] {
    OP_NOOP   = 2'd0,
    OP_GET    = 2'd1,
    OP_PUT    = 2'd2,
    OP_DELETE = 2'd3
  } operation_e;

endpackage

`default_nettype wire

// File: rtl/if_types_pkg.sv
// ============================================================================
// Module : if_types_pkg
// Brief  : Register-window types for the OBI cache front-end: FSM states,
//          STATUS bit positions, CMD encodings and word-map helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_types_pkg;
  import ctrl_types_pkg::*;

  typedef enum logic [1:0] {
    RIF_IDLE  = 2'd0,
    RIF_ISSUE = 2'd1,
    RIF_WAIT  = 2'd2
  } regif_state_e;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_SUCC    = 2;
  localparam int STAT_CMD_ERR = 3;

  localparam logic [1:0] CMD_NOOP   = 2'd0;
  localparam logic [1:0] CMD_GET    = 2'd1;
  localparam logic [1:0] CMD_PUT    = 2'd2;
  localparam logic [1:0] CMD_DELETE = 2'd3;

  // Word-map layout: KEY words first, then VALUE words, then CMD, then STATUS.
  function automatic int key_base();
    return 0;
  endfunction

  function automatic int val_base(input int kw);
    return kw;
  endfunction

  function automatic int cmd_word(input int kw, input int vw);
    return kw + vw;
  endfunction

  function automatic int stat_word(input int kw, input int vw);
    return kw + vw + 1;
  endfunction

  // Translate the CMD register field into the controller operation.
  function automatic operation_e cmd_to_op(input logic [1:0] cmd);
    operation_e op;
    case (cmd)
      CMD_GET:    op = OP_GET;
      CMD_PUT:    op = OP_PUT;
      CMD_DELETE: op = OP_DELETE;
      default:    op = OP_NOOP;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/obi_cache_regif_decode.sv
// ============================================================================
// Module : obi_cache_regif_decode
// Brief  : Combinational byte-address to register-select decoder for the
//          cache register window (one-hot KEY/VALUE word selects, CMD,
//          STATUS, and an unmapped flag).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_cache_regif_decode
  import if_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int KW     = 2,
  parameter int VW     = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [KW-1:0]     key_sel_o,
  output logic [VW-1:0]     val_sel_o,
  output logic              cmd_sel_o,
  output logic              stat_sel_o,
  output logic              unmapped_o
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int IW  = ADDR_W - OFF;

  logic [IW-1:0] w_widx;
  logic          w_unused_lo;

  assign w_widx      = addr_i[ADDR_W-1:OFF];
  // Sub-word address bits do not select a register.
  assign w_unused_lo = ^addr_i[OFF-1:0];

  // Compare the word index against every mapped register slot.
  always_comb begin
    key_sel_o  = '0;
    val_sel_o  = '0;
    for (int i = 0; i < KW; i++) begin
      key_sel_o[i] = (w_widx == IW'(key_base() + i));
    end
    for (int j = 0; j < VW; j++) begin
      val_sel_o[j] = (w_widx == IW'(val_base(KW) + j));
    end
    cmd_sel_o  = (w_widx == IW'(cmd_word(KW, VW)));
    stat_sel_o = (w_widx == IW'(stat_word(KW, VW)));
    unmapped_o = ~(|key_sel_o | |val_sel_o | cmd_sel_o | stat_sel_o);
  end

endmodule

`default_nettype wire

// File: rtl/obi_cache_regif.sv
// ============================================================================
// Module : obi_cache_regif
// Brief  : OBI slave register window in front of the cache controller.
//          Latches a wide key/value over several bus words, launches one
//          controller operation per CMD write and captures the result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_cache_regif
  import ctrl_types_pkg::*;
  import if_types_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int KEY_W   = 64,
  parameter int VALUE_W = 128,
  parameter int ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output operation_e          op_o,
  output logic                op_valid_o,
  input  logic                op_ready_i,
  output logic [KEY_W-1:0]    key_o,
  output logic [VALUE_W-1:0]  value_o,
  input  logic                done_i,
  input  logic                succ_i,
  input  logic [VALUE_W-1:0]  rvalue_i
);

  localparam int KW = KEY_W / DATA_W;
  localparam int VW = VALUE_W / DATA_W;
  localparam int NB = DATA_W / 8;

  regif_state_e        state_q, state_d;
  logic [KEY_W-1:0]    key_q;
  logic [VALUE_W-1:0]  val_q;
  logic                done_q, succ_q, cmd_err_q;
  operation_e          op_q;
  logic                rvalid_q, err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [KW-1:0]       w_key_sel;
  logic [VW-1:0]       w_val_sel;
  logic                w_cmd_sel, w_stat_sel, w_unmapped;
  logic                w_busy, w_gnt, w_err, w_wr_ok;
  logic                w_launch, w_noop, w_finish;
  logic [DATA_W-1:0]   w_status, w_rdata;

  obi_cache_regif_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .KW     (KW),
    .VW     (VW)
  ) u_decode (
    .addr_i     (addr_i),
    .key_sel_o  (w_key_sel),
    .val_sel_o  (w_val_sel),
    .cmd_sel_o  (w_cmd_sel),
    .stat_sel_o (w_stat_sel),
    .unmapped_o (w_unmapped)
  );

  // Only one transaction may be outstanding: no grant while a response waits.
  assign w_busy   = (state_q != RIF_IDLE);
  assign w_gnt    = req_i & ~rvalid_q;
  assign w_err    = w_unmapped
                  | (we_i & w_stat_sel)
                  | (we_i & w_busy & (|w_key_sel | |w_val_sel | w_cmd_sel));
  assign w_wr_ok  = w_gnt & we_i & ~w_err;
  assign w_launch = w_wr_ok & w_cmd_sel & (wdata_i[1:0] != CMD_NOOP);
  assign w_noop   = w_wr_ok & w_cmd_sel & (wdata_i[1:0] == CMD_NOOP);
  assign w_finish = (state_q == RIF_WAIT) & done_i;

  // Assemble STATUS and the read-data mux; errors and writes return zero.
  always_comb begin
    w_status               = '0;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_DONE]    = done_q;
    w_status[STAT_SUCC]    = succ_q;
    w_status[STAT_CMD_ERR] = cmd_err_q;
    w_rdata                = '0;
    if (!we_i && !w_err) begin
      for (int i = 0; i < KW; i++) begin
        if (w_key_sel[i]) w_rdata = key_q[i*DATA_W +: DATA_W];
      end
      for (int j = 0; j < VW; j++) begin
        if (w_val_sel[j]) w_rdata = val_q[j*DATA_W +: DATA_W];
      end
      if (w_stat_sel) w_rdata = w_status;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RIF_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; the operation request is offered for the whole ISSUE state.
  always_comb begin
    state_d    = state_q;
    op_valid_o = 1'b0;
    case (state_q)
      RIF_IDLE:  if (w_launch) state_d = RIF_ISSUE;
      RIF_ISSUE: begin
        op_valid_o = 1'b1;
        if (op_ready_i) state_d = RIF_WAIT;
      end
      RIF_WAIT:  if (done_i) state_d = RIF_IDLE;
      default:   state_d = RIF_IDLE;
    endcase
  end

  // KEY/VALUE storage: byte-enabled bus writes, GET result capture on success.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      val_q <= '0;
    end else begin
      for (int i = 0; i < KW; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_ok && w_key_sel[i] && be_i[b])
            key_q[i*DATA_W + b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      for (int j = 0; j < VW; j++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_ok && w_val_sel[j] && be_i[b])
            val_q[j*DATA_W + b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      if (w_finish && (op_q == OP_GET) && succ_i) val_q <= rvalue_i;
    end
  end

  // Operation latch and STATUS flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOOP;
      done_q    <= 1'b0;
      succ_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      if (w_launch) begin
        op_q      <= cmd_to_op(wdata_i[1:0]);
        done_q    <= 1'b0;
        succ_q    <= 1'b0;
        cmd_err_q <= 1'b0;
      end
      if (w_noop) begin
        done_q <= 1'b1;
        succ_q <= 1'b1;
      end
      if (w_finish) begin
        done_q <= 1'b1;
        succ_q <= succ_i;
      end
      if (w_gnt && we_i && w_cmd_sel && w_busy) cmd_err_q <= 1'b1;
    end
  end

  // Registered OBI response, held until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (w_gnt) begin
      rvalid_q <= 1'b1;
      err_q    <= w_err;
      rdata_q  <= w_rdata;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign op_o     = op_q;
  assign key_o    = key_q;
  assign value_o  = val_q;

endmodule

`default_nettype wire

// File: tb/tb_obi_cache_regif.sv
// ============================================================================
// Module : tb_obi_cache_regif
// Brief  : Directed self-checking bench for obi_cache_regif with a register
//          level behavioural model and a per-cycle output comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obi_cache_regif;
  import ctrl_types_pkg::*;

  localparam int KW = 2;
  localparam int VW = 4;
  localparam logic [7:0] A_CMD  = 8'd24;
  localparam logic [7:0] A_STAT = 8'd28;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_i = 1'b0, we_i = 1'b0, rready_i = 1'b1;
  logic [3:0]   be_i = 4'hF;
  logic [7:0]   addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         gnt_o, rvalid_o, err_o, op_valid_o;
  logic [31:0]  rdata_o;
  operation_e   op_o;
  logic         op_ready_i = 1'b0, done_i = 1'b0, succ_i = 1'b0;
  logic [63:0]  key_o;
  logic [127:0] value_o, rvalue_i = '0;

  obi_cache_regif #(.DATA_W(32), .KEY_W(64), .VALUE_W(128), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o), .op_o(op_o),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .key_o(key_o),
    .value_o(value_o), .done_i(done_i), .succ_i(succ_i), .rvalue_i(rvalue_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Register-level model: storage words, status flags, outstanding response.
  logic [31:0] mkey [KW];
  logic [31:0] mval [VW];
  logic [1:0]  m_op;
  logic [31:0] m_rdata;
  bit m_busy, m_opvalid, m_done, m_succ, m_cerr, m_rvalid, m_err;

  logic [31:0] rd;
  logic        er;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < KW; i++) mkey[i] = '0;
    for (int j = 0; j < VW; j++) mval[j] = '0;
    m_op = 2'd0; m_rdata = '0;
    m_busy = 0; m_opvalid = 0; m_done = 0; m_succ = 0; m_cerr = 0;
    m_rvalid = 0; m_err = 0;
  endtask

  // Apply one clock edge of the register-window rules to the model.
  task automatic model_edge();
    bit g, pb, pov, kh, vh, ch, sh, e;
    int w;
    logic [31:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pb  = m_busy;
    pov = m_opvalid;
    g   = req_i && !m_rvalid;
    w   = int'(addr_i) / 4;
    kh  = (w < KW);
    vh  = (w >= KW) && (w < KW + VW);
    ch  = (w == KW + VW);
    sh  = (w == KW + VW + 1);
    e   = !(kh || vh || ch || sh) || (we_i && sh) || (we_i && pb && (kh || vh || ch));
    r   = '0;
    if (!we_i && !e) begin
      if (kh)      r = mkey[w];
      else if (vh) r = mval[w - KW];
      else if (sh) r = {28'd0, m_cerr, m_succ, m_done, pb};
    end
    if (pb) begin
      if (pov) begin
        if (op_ready_i) m_opvalid = 0;
      end else if (done_i) begin
        m_busy = 0; m_done = 1; m_succ = succ_i;
        if (m_op == 2'd1 && succ_i)
          for (int j = 0; j < VW; j++) mval[j] = rvalue_i[32*j +: 32];
      end
    end
    if (m_rvalid && rready_i) m_rvalid = 0;
    if (g) begin
      m_rvalid = 1; m_rdata = r; m_err = e;
      if (we_i && !e) begin
        if (kh || vh) begin
          for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
              if (kh) mkey[w][8*b +: 8] = wdata_i[8*b +: 8];
              else    mval[w - KW][8*b +: 8] = wdata_i[8*b +: 8];
            end
          end
        end else if (ch) begin
          if (wdata_i[1:0] == 2'd0) begin
            m_done = 1; m_succ = 1;
          end else begin
            m_busy = 1; m_opvalid = 1; m_op = wdata_i[1:0];
            m_done = 0; m_succ = 0; m_cerr = 0;
          end
        end
      end
      if (we_i && ch && pb) m_cerr = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Compare every DUT output against the model in mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_op_valid", op_valid_o, 128'd0);
      chk("rst_rvalid", rvalid_o, 128'd0);
      chk("rst_err", err_o, 128'd0);
      chk("rst_rdata", rdata_o, 128'd0);
      chk("rst_op", op_o, 128'(OP_NOOP));
    end else begin
      chk("gnt", gnt_o, req_i && !m_rvalid);
      chk("rvalid", rvalid_o, m_rvalid);
      if (m_rvalid) begin
        chk("rdata", rdata_o, m_rdata);
        chk("err", err_o, m_err);
      end
      chk("op_valid", op_valid_o, m_opvalid);
      if (m_opvalid) begin
        chk("op", op_o, m_op);
        chk("key", key_o, {mkey[1], mkey[0]});
        chk("value", value_o, {mval[3], mval[2], mval[1], mval[0]});
      end
    end
  end

  task automatic bus(input bit we, input logic [7:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rdat, output logic erv);
    int n;
    bit g;
    req_i = 1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    n = 0;
    do begin
      g = !m_rvalid;
      cycle();
      n++;
    end while (!g && n < 50);
    req_i = 0; we_i = 0;
    if (!g) chk("bus_grant_timeout", 0, 1);
    n = 0;
    while (!rvalid_o && n < 50) begin
      cycle();
      n++;
    end
    if (!rvalid_o) chk("bus_rvalid_timeout", 0, 1);
    rdat = rdata_o;
    erv  = err_o;
    cycle();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
    bus(0, a, '0, 4'hF, rd, er);
    chk({name, "_data"}, rd, exp_d);
    chk({name, "_err"}, er, exp_e);
  endtask

  task automatic wr_chk(input string name, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic exp_e);
    bus(1, a, d, be, rd, er);
    chk({name, "_err"}, er, exp_e);
  endtask

  task automatic accept_op();
    op_ready_i = 1; cycle(); op_ready_i = 0;
  endtask

  task automatic finish_op(input logic s, input logic [127:0] rv);
    done_i = 1; succ_i = s; rvalue_i = rv;
    cycle();
    done_i = 0; succ_i = 0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
    chk("reset_op_valid", op_valid_o, 0);
    chk("reset_rvalid", rvalid_o, 0);
    chk("reset_op", op_o, OP_NOOP);
    rd_chk("reset_status", A_STAT, 32'h0, 0);

    // PUT of a two-word key and four-word value.
    wr_chk("key0", 8'd0, 32'h11111111, 4'hF, 0);
    wr_chk("key1", 8'd4, 32'h22222222, 4'hF, 0);
    for (int j = 0; j < VW; j++) wr_chk("val", 8'(8 + 4*j), 32'hA + j, 4'hF, 0);
    wr_chk("cmd_put", A_CMD, 32'd2, 4'hF, 0);
    chk("put_op_valid", op_valid_o, 1);
    chk("put_op", op_o, OP_PUT);
    chk("put_key", key_o, 64'h22222222_11111111);
    chk("put_value", value_o, 128'h0000000D_0000000C_0000000B_0000000A);
    repeat (5) cycle();
    chk("stall_op_valid", op_valid_o, 1);
    chk("stall_key", key_o, 64'h22222222_11111111);
    rd_chk("busy_status", A_STAT, 32'h1, 0);
    accept_op();
    chk("accepted_op_valid", op_valid_o, 0);
    finish_op(1, '0);
    rd_chk("put_status", A_STAT, 32'h6, 0);

    // Successful GET overwrites VALUE.
    wr_chk("cmd_get", A_CMD, 32'd1, 4'hF, 0);
    accept_op();
    finish_op(1, 128'hDEAD0000_11112222_33334444_0000BEEF);
    rd_chk("get_status", A_STAT, 32'h6, 0);
    rd_chk("get_val0", 8'd8, 32'h0000BEEF, 0);
    rd_chk("get_val3", 8'd20, 32'hDEAD0000, 0);

    // Failed GET leaves VALUE alone.
    wr_chk("cmd_get2", A_CMD, 32'd1, 4'hF, 0);
    accept_op();
    finish_op(0, 128'h12345678_12345678_12345678_12345678);
    rd_chk("getfail_status", A_STAT, 32'h2, 0);
    rd_chk("getfail_val0", 8'd8, 32'h0000BEEF, 0);

    // NOOP completes immediately.
    wr_chk("cmd_noop", A_CMD, 32'd0, 4'hF, 0);
    chk("noop_op_valid", op_valid_o, 0);
    rd_chk("noop_status", A_STAT, 32'h6, 0);

    // DELETE with writes attempted while busy and a stray done in ISSUE.
    wr_chk("cmd_del", A_CMD, 32'd3, 4'hF, 0);
    done_i = 1; succ_i = 1; cycle(); done_i = 0; succ_i = 0;
    wr_chk("busy_cmd", A_CMD, 32'd2, 4'hF, 1);
    wr_chk("busy_key", 8'd0, 32'h0, 4'hF, 1);
    rd_chk("busy_err_status", A_STAT, 32'h9, 0);
    chk("del_op", op_o, OP_DELETE);
    accept_op();
    finish_op(1, '0);
    rd_chk("del_status", A_STAT, 32'hE, 0);

    // Unmapped access and STATUS write.
    rd_chk("unmapped", 8'h80, 32'h0, 1);
    wr_chk("status_wr", A_STAT, 32'hFFFFFFFF, 4'hF, 1);

    // Byte-enabled KEY write.
    wr_chk("key_be", 8'd0, 32'hFFFFFFFF, 4'b0010, 0);
    rd_chk("key_be_rd", 8'd0, 32'h1111FF11, 0);

    // Response held while the master stalls; second request waits.
    rready_i = 0; req_i = 1; we_i = 0; addr_i = 8'd4;
    cycle();
    addr_i = 8'd0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_gnt", gnt_o, 0);
      chk("stall_rvalid", rvalid_o, 1);
      chk("stall_rdata", rdata_o, 32'h22222222);
      cycle();
    end
    rready_i = 1;
    cycle();
    chk("regrant", gnt_o, 1);
    cycle();
    req_i = 0;
    chk("second_rdata", rdata_o, 32'h1111FF11);
    cycle();

    // Reset while waiting on the controller with a response pending.
    wr_chk("cmd_put2", A_CMD, 32'd2, 4'hF, 0);
    accept_op();
    rready_i = 0; req_i = 1; addr_i = A_STAT;
    cycle();
    req_i = 0;
    cycle();
    chk("pending_rvalid", rvalid_o, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_rvalid", rvalid_o, 0);
    chk("async_op_valid", op_valid_o, 0);
    cycle();
    rst_n = 1; rready_i = 1;
    cycle();
    rd_chk("post_rst_status", A_STAT, 32'h0, 0);
    rd_chk("post_rst_key0", 8'd0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
